regfile_2w2r_sb: RTL and testbench
==================================

// Module: regfile_2w2r_sb
// PURPOSE
//  Parametrised integer register file for the RV32 core: 2 registered read ports, 2 write ports
//  (WB0 = ALU writeback, WB1 = load/long-latency writeback) and a per-register busy scoreboard.
//  Sits between decode (reads, issue) and writeback; drives the decode stall via 'hazard'.
//  Same-cycle write->read bypass removes the write-then-read bubble.
// PARAMETERS
//  XLEN   32  data width in bits
//  NREGS  16  architectural registers incl. x0 (16 = RV32E, 32 = RV32I)
//  AW     $clog2(NREGS)  register index width (derived; not overridden)
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  reset        in   1     asynchronous, active-high reset
//  re           in   1     read enable; read_data_* update only when high
//  rs1          in   AW    read port 1 index
//  rs2          in   AW    read port 2 index
//  read_data_1  out  XLEN  registered read data, port 1
//  read_data_2  out  XLEN  registered read data, port 2
//  we0          in   1     write enable, WB0
//  rd0          in   AW    destination, WB0
//  wdata0       in   XLEN  write data, WB0
//  we1          in   1     write enable, WB1
//  rd1          in   AW    destination, WB1
//  wdata1       in   XLEN  write data, WB1
//  issue_valid  in   1     instruction issued this cycle; marks issue_rd busy
//  issue_rd     in   AW    destination of issued instruction
//  hazard       out  1     combinational: rs1, rs2 or issue_rd awaits a pending write
//  busy_vec     out  NREGS registered busy bits, bit 0 always 0
// BEHAVIOUR
//  - Reset (async): all registers, read_data_1/2 and busy_vec to 0 immediately; hazard then 0.
//    Reset mid-operation discards pending writes/issues; no write lands in the reset cycle.
//  - x0: writes to index 0 ignored; reads of index 0 return 0; issue to x0 never sets busy.
//  - Write: on edge, weN && rdN!=0 -> reg[rdN] <= wdataN. If we0 && we1 && rd0==rd1, WB1 wins.
//  - Read latency 1 cycle. On edge with re=1: read_data_k <= value of rs_k after this edge's
//    writes (bypass: WB1 data if we1 && rd1==rs_k, else WB0 data if we0 && rd0==rs_k, else reg).
//    re=0: read_data_* hold.
//  - Scoreboard, per register r!=0, next busy[r]:
//      set   if issue_valid && issue_rd==r
//      else clear if (we0 && rd0==r) || (we1 && rd1==r)
//      else hold. Issue wins over same-cycle clear (new producer owns r).
//    Re-issue to an already busy r keeps it busy (single bit; decode must not issue WAW, see hazard).
//  - hazard = pend(rs1) | pend(rs2) | (issue_valid & pend(issue_rd)), where
//    pend(r) = busy[r] & r!=0 & ~(writing r this cycle on WB0 or WB1). A register being written
//    this cycle is not a hazard: the bypass supplies its value.
//  - Caller holds issue_valid low while hazard is high; the block does not gate it internally.
// STRUCTURE
//  - Shared package riscv_pkg: XLEN, NREGS, AW constants, reg index typedef, ZERO constant.
//  - Sub-module reg_scoreboard (busy_vec state, set/clear priority, pend/hazard logic);
//    storage, bypass mux and read registers in this top module.
//  - Storage: flop array for indices 1..NREGS-1; no index-0 storage.
// TESTING
//  1. Assert reset mid-stream with x5=0xDEADBEEF, busy[5]=1 -> read_data_1/2, busy_vec 0 at once; read x5 -> 0.
//  2. we0=1 rd0=0 wdata0=0xFFFFFFFF, then re rs1=0 -> read_data_1=0; issue_rd=0 -> busy_vec=0, hazard=0.
//  3. Same edge we0 rd0=3 wdata0=0x11, we1 rd1=3 wdata1=0x22, re rs1=3 -> read_data_1=0x22 next cycle; x3 stays 0x22.
//  4. Issue rd=7; next cycle rs1=7 -> hazard=1; cycle with we1 rd1=7 wdata1=0xA5, re=1 -> hazard=0,
//     read_data_1=0xA5 after edge, busy_vec[7]=0.
//  5. Same edge issue_rd=4 and we0 rd0=4 -> busy_vec[4]=1 afterwards; x4 holds written data.
//  6. re=0 with writes to rs1/rs2 -> read_data_1/2 unchanged; re=1 next cycle -> new values.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core constants: data width, register count and register index type.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0] reg_idx_t;

    localparam reg_idx_t ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits with issue/writeback priority and decode hazard detection.
module reg_scoreboard #(
    parameter  int NREGS = riscv_pkg::NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             we0,
    input  logic [AW-1:0]    rd0,
    input  logic             we1,
    input  logic [AW-1:0]    rd1,
    output logic             hazard,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] wr_vec;
    logic [NREGS-1:0] pend_vec;

    always_comb begin
        busy_d   = '0;
        wr_vec   = '0;
        pend_vec = '0;
        for (int r = 1; r < NREGS; r++) begin
            wr_vec[r]   = (we0 && rd0 == AW'(r)) || (we1 && rd1 == AW'(r));
            // A register being written now is covered by the bypass.
            pend_vec[r] = busy_q[r] & ~wr_vec[r];
            if (issue_valid && issue_rd == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else if (wr_vec[r]) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
    end

    always_comb begin
        hazard = pend_vec[rs1] | pend_vec[rs2]
               | (issue_valid & pend_vec[issue_rd]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_2w2r_sb.sv
// Integer register file: two registered read ports with write bypass,
// two writeback ports and a busy scoreboard driving the decode stall.
module regfile_2w2r_sb #(
    parameter  int XLEN  = riscv_pkg::XLEN,
    parameter  int NREGS = riscv_pkg::NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             re,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic [XLEN-1:0]  read_data_1,
    output logic [XLEN-1:0]  read_data_2,
    input  logic             we0,
    input  logic [AW-1:0]    rd0,
    input  logic [XLEN-1:0]  wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    rd1,
    input  logic [XLEN-1:0]  wdata1,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             hazard,
    output logic [NREGS-1:0] busy_vec
);

    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];
    logic [XLEN-1:0] rdata1_q, rdata1_d;
    logic [XLEN-1:0] rdata2_q, rdata2_d;

    // WB1 is applied last so it wins a same-index collision.
    always_comb begin
        regs_d = regs_q;
        if (we0 && rd0 != '0) begin
            regs_d[rd0] = wdata0;
        end
        if (we1 && rd1 != '0) begin
            regs_d[rd1] = wdata1;
        end
    end

    // Reading the post-write array gives the bypass for free.
    always_comb begin
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        if (re) begin
            rdata1_d = (rs1 == '0) ? '0 : regs_d[rs1];
            rdata2_d = (rs2 == '0) ? '0 : regs_d[rs2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            regs_q   <= regs_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    assign read_data_1 = rdata1_q;
    assign read_data_2 = rdata2_q;

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .rs1         (rs1),
        .rs2         (rs2),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .we0         (we0),
        .rd0         (rd0),
        .we1         (we1),
        .rd1         (rd1),
        .hazard      (hazard),
        .busy_vec    (busy_vec)
    );

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Self-checking bench for regfile_2w2r_sb: reference model plus read-data scoreboard.
module tb_regfile_2w2r_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        re;
    logic [3:0]  rs1, rs2;
    logic [31:0] read_data_1, read_data_2;
    logic        we0, we1;
    logic [3:0]  rd0, rd1;
    logic [31:0] wdata0, wdata1;
    logic        issue_valid;
    logic [3:0]  issue_rd;
    logic        hazard;
    logic [15:0] busy_vec;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mregs [16];
    logic [15:0] mbusy;
    logic [31:0] m1, m2;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    regfile_2w2r_sb dut (
        .clk         (clk),
        .reset       (reset),
        .re          (re),
        .rs1         (rs1),
        .rs2         (rs2),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .we0         (we0),
        .rd0         (rd0),
        .wdata0      (wdata0),
        .we1         (we1),
        .rd1         (rd1),
        .wdata1      (wdata1),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .hazard      (hazard),
        .busy_vec    (busy_vec)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic writing(input logic [3:0] r);
        return (we0 && rd0 == r) || (we1 && rd1 == r);
    endfunction

    function automatic logic pend(input logic [3:0] r);
        return mbusy[r] && r != 4'd0 && !writing(r);
    endfunction

    task automatic idle();
        re = 0; rs1 = 0; rs2 = 0;
        we0 = 0; rd0 = 0; wdata0 = 0;
        we1 = 0; rd1 = 0; wdata1 = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mbusy = '0;
        m1 = '0;
        m2 = '0;
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic cyc();
        logic [31:0] nr [16];
        logic [15:0] nb;
        logic        hz;
        exp_t        e;
        #1;
        hz = pend(rs1) | pend(rs2) | (issue_valid & pend(issue_rd));
        check("hazard", {31'b0, hazard}, {31'b0, hz});
        nr = mregs;
        if (we0 && rd0 != 0) nr[rd0] = wdata0;
        if (we1 && rd1 != 0) nr[rd1] = wdata1;
        if (re) begin
            m1 = nr[rs1];
            m2 = nr[rs2];
        end
        e.a = m1;
        e.b = m2;
        exp_q.push_back(e);
        nb = mbusy;
        for (int r = 1; r < 16; r++) begin
            if (issue_valid && issue_rd == 4'(r)) nb[r] = 1'b1;
            else if (writing(4'(r)))             nb[r] = 1'b0;
        end
        mregs = nr;
        mbusy = nb;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("rdata1", read_data_1, e.a);
        check("rdata2", read_data_2, e.b);
        check("busy", {16'b0, busy_vec}, {16'b0, mbusy});
        @(negedge clk);
    endtask

    initial begin
        idle();
        model_reset();
        reset = 1;
        #3;
        check("rst_rdata1", read_data_1, 32'h0);
        check("rst_rdata2", read_data_2, 32'h0);
        check("rst_busy", {16'b0, busy_vec}, 32'h0);
        check("rst_hazard", {31'b0, hazard}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;

        // Mid-stream reset with x5 written, busy and visible on both ports.
        idle(); we0 = 1; rd0 = 5; wdata0 = 32'hDEADBEEF; cyc();
        idle(); issue_valid = 1; issue_rd = 5; re = 1; rs1 = 5; rs2 = 5; cyc();
        idle();
        #2;
        reset = 1;
        we0 = 1; rd0 = 5; wdata0 = 32'h12345678;
        #1;
        model_reset();
        check("mid_rst_rdata1", read_data_1, 32'h0);
        check("mid_rst_rdata2", read_data_2, 32'h0);
        check("mid_rst_busy", {16'b0, busy_vec}, 32'h0);
        @(negedge clk);
        idle();
        reset = 0;
        re = 1; rs1 = 5; rs2 = 5; cyc();

        // x0 is hardwired: writes ignored, never busy.
        idle(); we0 = 1; rd0 = 0; wdata0 = 32'hFFFFFFFF; cyc();
        idle(); re = 1; rs1 = 0; rs2 = 0; cyc();
        idle(); issue_valid = 1; issue_rd = 0; cyc();
        idle(); re = 1; rs1 = 0; cyc();

        // WB1 wins a same-index collision, also through the bypass.
        idle(); we0 = 1; rd0 = 3; wdata0 = 32'h11;
        we1 = 1; rd1 = 3; wdata1 = 32'h22; re = 1; rs1 = 3; cyc();
        idle(); re = 1; rs1 = 3; rs2 = 3; cyc();

        // Issue, hazard while pending, cleared by the bypassed write.
        idle(); issue_valid = 1; issue_rd = 7; cyc();
        idle(); rs1 = 7; cyc();
        idle(); rs2 = 7; cyc();
        idle(); issue_rd = 7; cyc();
        idle(); re = 1; rs1 = 7; we1 = 1; rd1 = 7; wdata1 = 32'hA5; cyc();

        // Issue beats a same-cycle clear; data still lands.
        idle(); issue_valid = 1; issue_rd = 4; we0 = 1; rd0 = 4; wdata0 = 32'h44; cyc();
        idle(); rs1 = 4; cyc();
        idle(); we1 = 1; rd1 = 4; wdata1 = 32'h45; re = 1; rs1 = 4; cyc();

        // re=0 holds outputs even while the read indices are written.
        idle(); re = 1; rs1 = 3; rs2 = 4; cyc();
        idle(); we0 = 1; rd0 = 3; wdata0 = 32'h333;
        we1 = 1; rd1 = 4; wdata1 = 32'h444; rs1 = 3; rs2 = 4; cyc();
        idle(); re = 1; rs1 = 3; rs2 = 4; cyc();

        // Random traffic; issue only when the model says it is legal.
        for (int i = 0; i < 300; i++) begin
            idle();
            re     = 1'($urandom_range(0, 1));
            rs1    = 4'($urandom_range(0, 15));
            rs2    = 4'($urandom_range(0, 15));
            we0    = 1'($urandom_range(0, 1));
            rd0    = 4'($urandom_range(0, 15));
            wdata0 = $urandom;
            we1    = 1'($urandom_range(0, 1));
            rd1    = 4'($urandom_range(0, 15));
            wdata1 = $urandom;
            issue_rd = 4'($urandom_range(0, 15));
            issue_valid = 1'($urandom_range(0, 1));
            if (pend(rs1) | pend(rs2) | pend(issue_rd)) issue_valid = 0;
            cyc();
        end

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
